// File: rtl/dino_pkg.sv
//------------------------------------------------------------------------------
// Module      : dino_pkg
// Description : Shared obstacle defaults and the obstacle-type enumeration.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dino_pkg;

  localparam int unsigned OBS_POS_W   = 9;
  localparam int unsigned OBS_TYPE_W  = 3;
  localparam int unsigned OBS_SPAWN_X = 319;

  // Also decoded by obs_render; keep encodings stable.
  typedef enum logic [OBS_TYPE_W-1:0] {
    OBS_CACTUS_SMALL = 3'd0,
    OBS_CACTUS_LARGE = 3'd1,
    OBS_CACTUS_GROUP = 3'd2,
    OBS_BIRD_LOW     = 3'd3,
    OBS_BIRD_MID     = 3'd4,
    OBS_BIRD_HIGH    = 3'd5,
    OBS_RSVD_6       = 3'd6,
    OBS_RSVD_7       = 3'd7
  } obs_type_e;

endpackage : dino_pkg

`default_nettype wire

// File: rtl/obstacle_slot.sv
//------------------------------------------------------------------------------
// Module      : obstacle_slot
// Description : One obstacle slot: position/type/valid registers, move, retire
//               and load.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module obstacle_slot
  import dino_pkg::*;
#(
  parameter int unsigned POS_W  = OBS_POS_W,
  parameter int unsigned TYPE_W = OBS_TYPE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              update_i,
  input  logic [3:0]        speed_i,
  input  logic              load_i,
  input  logic [POS_W-1:0]  load_pos_i,
  input  logic [TYPE_W-1:0] load_type_i,
  output logic [POS_W-1:0]  pos_o,
  output logic [TYPE_W-1:0] type_o,
  output logic              valid_o,
  output logic              free_o
);

  localparam int unsigned CW = (POS_W > 4) ? POS_W : 4;

  logic [POS_W-1:0]  pos_q,   pos_d;
  logic [TYPE_W-1:0] type_q,  type_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     w_pos_ext;
  logic [CW-1:0]     w_spd_ext;
  logic              w_retire;

  assign w_pos_ext = CW'(pos_q);
  assign w_spd_ext = CW'(speed_i);
  assign w_retire  = valid_q && (w_pos_ext < w_spd_ext);

  // Free after this cycle's move/retire, so a retiring slot can be reloaded at once.
  assign free_o = !valid_q || w_retire;

  always_comb begin
    pos_d   = pos_q;
    type_d  = type_q;
    valid_d = valid_q;
    if (clear_i) begin
      pos_d   = '0;
      type_d  = '0;
      valid_d = 1'b0;
    end else if (update_i) begin
      if (w_retire) begin
        pos_d   = '0;
        type_d  = '0;
        valid_d = 1'b0;
      end else if (valid_q) begin
        pos_d = POS_W'(w_pos_ext - w_spd_ext);
      end
      if (load_i) begin
        pos_d   = load_pos_i;
        type_d  = load_type_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      type_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      type_q  <= type_d;
      valid_q <= valid_d;
    end
  end

  assign pos_o   = pos_q;
  assign type_o  = type_q;
  assign valid_o = valid_q;

endmodule : obstacle_slot

`default_nettype wire

// File: rtl/obstacle_scheduler.sv
//------------------------------------------------------------------------------
// Module      : obstacle_scheduler
// Description : NUM_OBS-slot obstacle engine with random spawn gap/type and a
//               saturating speed ramp.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter int unsigned NUM_OBS    = 3,
  parameter int unsigned POS_W      = OBS_POS_W,
  parameter int unsigned TYPE_W     = OBS_TYPE_W,
  parameter int unsigned SPAWN_X    = OBS_SPAWN_X,
  parameter int unsigned MIN_GAP    = 30,
  parameter int unsigned SPEED_INIT = 2,
  parameter int unsigned SPEED_MAX  = 6,
  parameter int unsigned SPEED_STEP = 600
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      game_tick,
  input  logic                      game_start,
  input  logic                      run,
  input  logic [7:0]                rng,
  output logic [NUM_OBS*POS_W-1:0]  obs_pos,
  output logic [NUM_OBS*TYPE_W-1:0] obs_type,
  output logic [NUM_OBS-1:0]        obs_valid,
  output logic [3:0]                speed,
  output logic                      spawn_pulse
);

  localparam int unsigned RW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

  logic [7:0]         gap_q,   gap_d;
  logic [RW-1:0]      ramp_q,  ramp_d;
  logic [3:0]         speed_q, speed_d;
  logic               spawn_q, spawn_d;
  logic               w_update;
  logic               w_slot_update;
  logic               w_spawn;
  logic               w_any_free;
  logic [NUM_OBS-1:0] w_free;
  logic [NUM_OBS-1:0] w_load;
  logic               w_rng_unused;

  assign w_update      = game_tick && run;
  assign w_slot_update = w_update && !game_start;
  assign w_any_free    = |w_free;
  assign w_spawn       = w_slot_update && (gap_q == 8'd0) && w_any_free;
  assign w_rng_unused  = ^rng;

  // Lowest-index free slot wins the spawn.
  always_comb begin
    logic found;
    found  = 1'b0;
    w_load = '0;
    for (int i = 0; i < int'(NUM_OBS); i++) begin
      if (!found && w_free[i]) begin
        w_load[i] = w_spawn;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    gap_d   = gap_q;
    ramp_d  = ramp_q;
    speed_d = speed_q;
    spawn_d = 1'b0;
    if (game_start) begin
      gap_d   = 8'(MIN_GAP);
      ramp_d  = '0;
      speed_d = 4'(SPEED_INIT);
    end else if (w_update) begin
      if (w_spawn) begin
        gap_d   = 8'(MIN_GAP) + {4'b0000, rng[7:4]};
        spawn_d = 1'b1;
      end else if (gap_q != 8'd0) begin
        gap_d = gap_q - 8'd1;
      end
      if (ramp_q == RW'(SPEED_STEP - 1)) begin
        ramp_d = '0;
        if (speed_q < 4'(SPEED_MAX)) begin
          speed_d = speed_q + 4'd1;
        end
      end else begin
        ramp_d = ramp_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q   <= 8'(MIN_GAP);
      ramp_q  <= '0;
      speed_q <= 4'(SPEED_INIT);
      spawn_q <= 1'b0;
    end else begin
      gap_q   <= gap_d;
      ramp_q  <= ramp_d;
      speed_q <= speed_d;
      spawn_q <= spawn_d;
    end
  end

  generate
    for (genvar g = 0; g < int'(NUM_OBS); g++) begin : g_slot
      obstacle_slot #(
        .POS_W  (POS_W),
        .TYPE_W (TYPE_W)
      ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (game_start),
        .update_i    (w_slot_update),
        .speed_i     (speed_q),
        .load_i      (w_load[g]),
        .load_pos_i  (POS_W'(SPAWN_X)),
        .load_type_i (rng[TYPE_W-1:0]),
        .pos_o       (obs_pos[g*POS_W +: POS_W]),
        .type_o      (obs_type[g*TYPE_W +: TYPE_W]),
        .valid_o     (obs_valid[g]),
        .free_o      (w_free[g])
      );
    end
  endgenerate

  assign speed       = speed_q;
  assign spawn_pulse = spawn_q;

endmodule : obstacle_scheduler

`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_obstacle_scheduler
// Description : Directed self-checking bench for obstacle_scheduler (defaults).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_obstacle_scheduler;

  logic        clk;
  logic        rst_n;
  logic        game_tick;
  logic        game_start;
  logic        run;
  logic [7:0]  rng;
  logic [26:0] obs_pos;
  logic [8:0]  obs_type;
  logic [2:0]  obs_valid;
  logic [3:0]  speed;
  logic        spawn_pulse;

  int errors = 0;
  int checks = 0;

  obstacle_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_tick   (game_tick),
    .game_start  (game_start),
    .run         (run),
    .rng         (rng),
    .obs_pos     (obs_pos),
    .obs_type    (obs_type),
    .obs_valid   (obs_valid),
    .speed       (speed),
    .spawn_pulse (spawn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      game_tick = 1'b1;
      @(posedge clk);
      #1;
      game_tick = 1'b0;
    end
  endtask

  task automatic start_game();
    @(negedge clk);
    game_start = 1'b1;
    @(posedge clk);
    #1;
    game_start = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b1;
    game_tick  = 1'b0;
    game_start = 1'b0;
    run        = 1'b0;
    rng        = 8'h00;
    #2 rst_n = 1'b0;
    #20;
    check("rst_valid", obs_valid, 3'b000);
    check("rst_pos",   obs_pos, 27'd0);
    check("rst_type",  obs_type, 9'd0);
    check("rst_speed", speed, 4'd2);
    check("rst_spawn", spawn_pulse, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;

    // First spawn after MIN_GAP+1 ticks
    start_game();
    check("start_speed", speed, 4'd2);
    tick(30);
    check("no_early_spawn", obs_valid, 3'b000);
    tick(1);
    check("spawn1_valid", obs_valid, 3'b001);
    check("spawn1_pos",   obs_pos, {9'd0, 9'd0, 9'd319});
    check("spawn1_type",  obs_type, 9'd0);
    check("spawn1_pulse", spawn_pulse, 1'b1);
    tick(1);
    check("move1_pos",   obs_pos, {9'd0, 9'd0, 9'd317});
    check("move1_pulse", spawn_pulse, 1'b0);

    // Gap 30+5=35 -> spawn every 36 ticks; slots fill in order, then reuse
    rng = 8'h53;
    start_game();
    check("restart_valid", obs_valid, 3'b000);
    check("restart_pos",   obs_pos, 27'd0);
    tick(31);
    check("s2_t31_type", obs_type, 9'o003);
    tick(36);
    check("s2_t67_valid", obs_valid, 3'b011);
    check("s2_t67_pos",   obs_pos, {9'd0, 9'd319, 9'd247});
    check("s2_t67_type",  obs_type, 9'o033);
    check("s2_t67_pulse", spawn_pulse, 1'b1);
    tick(36);
    check("s2_t103_valid", obs_valid, 3'b111);
    check("s2_t103_pos",   obs_pos, {9'd319, 9'd247, 9'd175});
    tick(36);
    check("s2_full_nospawn", spawn_pulse, 1'b0);
    check("s2_full_valid",   obs_valid, 3'b111);
    tick(51);
    check("s2_t190_pos", obs_pos, {9'd145, 9'd73, 9'd1});
    tick(1);
    check("s2_t191_pos",   obs_pos, {9'd143, 9'd71, 9'd319});
    check("s2_t191_valid", obs_valid, 3'b111);
    check("s2_t191_pulse", spawn_pulse, 1'b1);
    tick(36);
    check("s2_t227_pos",   obs_pos, {9'd71, 9'd319, 9'd247});
    check("s2_t227_pulse", spawn_pulse, 1'b1);

    // Freeze
    @(negedge clk);
    run = 1'b0;
    rng = 8'hFF;
    tick(100);
    check("frz_pos",   obs_pos, {9'd71, 9'd319, 9'd247});
    check("frz_valid", obs_valid, 3'b111);
    check("frz_type",  obs_type, 9'o333);
    check("frz_speed", speed, 4'd2);
    check("frz_pulse", spawn_pulse, 1'b0);
    @(negedge clk);
    run = 1'b1;
    tick(1);
    check("resume_pos", obs_pos, {9'd69, 9'd317, 9'd245});
    @(negedge clk);
    run = 1'b0;
    start_game();
    check("frz_start_valid", obs_valid, 3'b000);
    check("frz_start_pos",   obs_pos, 27'd0);
    check("frz_start_type",  obs_type, 9'd0);
    check("frz_start_speed", speed, 4'd2);

    // Speed ramp every 600 ticks, saturating at 6
    rng = 8'h00;
    @(negedge clk);
    run = 1'b1;
    start_game();
    tick(599);
    check("ramp_t599_speed", speed, 4'd2);
    check("ramp_t599_pos0",  obs_pos[8:0], 9'd143);
    tick(1);
    check("ramp_t600_speed", speed, 4'd3);
    check("ramp_t600_pos0",  obs_pos[8:0], 9'd141);
    tick(1);
    check("ramp_t601_pos0",  obs_pos[8:0], 9'd138);
    tick(598);
    check("ramp_t1199_speed", speed, 4'd3);
    tick(1);
    check("ramp_t1200_speed", speed, 4'd4);
    tick(600);
    check("ramp_t1800_speed", speed, 4'd5);
    tick(600);
    check("ramp_t2400_speed", speed, 4'd6);
    tick(1200);
    check("ramp_sat_speed", speed, 4'd6);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("areset1_speed", speed, 4'd2);
    check("areset1_valid", obs_valid, 3'b000);
    check("areset1_pos",   obs_pos, 27'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rng   = 8'h21;
    start_game();
    tick(64);
    check("pre_areset_valid", obs_valid, 3'b011);
    check("pre_areset_pos",   obs_pos, {9'd0, 9'd319, 9'd253});
    check("pre_areset_type",  obs_type, 9'o011);
    check("pre_areset_pulse", spawn_pulse, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("areset2_valid", obs_valid, 3'b000);
    check("areset2_pos",   obs_pos, 27'd0);
    check("areset2_type",  obs_type, 9'd0);
    check("areset2_pulse", spawn_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_obstacle_scheduler

`default_nettype wire
